// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end. Holds the PC, fetches the word
// at PC over a Req/Ack memory handshake, and presents it to decode over a
// Valid/Ready handshake. A redirect that arrives while a fetch is outstanding
// is remembered (kill flag + target register) so the address stays stable
// until the memory answers.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned PC loads trap instead
// of being force-aligned).
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Next_PC,
    input  logic        Redirect,
    output logic [31:0] PC,
    output logic [31:0] PC_Plus4,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Data,
    output logic [31:0] Instr,
    output logic [31:0] Instr_PC,
    output logic        Instr_Valid,
    input  logic        Instr_Ready,
    output logic        Misalign_Trap
);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, TRAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        kill_q, kill_d;
    logic [31:0] redir_q, redir_d;
    logic        load_req;
    logic [31:0] load_tgt;

    // State register: all sequential state, synchronous active-high reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            kill_q     <= 1'b0;
            redir_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            kill_q     <= kill_d;
            redir_q    <= redir_d;
        end
    end

    // Next-state logic: FSM transitions plus PC / instruction / redirect updates
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        kill_d     = kill_q;
        redir_d    = redir_q;
        load_req   = 1'b0;
        load_tgt   = Next_PC;

        case (state_q)
            IDLE: begin
                if (Redirect) load_req = 1'b1;
                else          state_d  = FETCH;
            end
            FETCH: begin
                if (IMem_Ack) begin
                    // A same-cycle redirect supersedes any latched target
                    if (Redirect) begin
                        load_req = 1'b1;
                    end else if (kill_q) begin
                        load_req = 1'b1;
                        load_tgt = redir_q;
                    end else begin
                        instr_d    = IMem_Data;
                        instr_pc_d = pc_q;
                        state_d    = HOLD;
                    end
                    kill_d = 1'b0;
                end else if (Redirect) begin
                    // PC must stay put while Req is high; remember the target
                    redir_d = Next_PC;
                    kill_d  = 1'b1;
                end
            end
            HOLD: begin
                if (Redirect || Instr_Ready) load_req = 1'b1;
            end
`ifdef MISALIGN_TRAP_EN
            TRAP: begin
                if (Redirect && (Next_PC[1:0] == 2'b00)) load_req = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (load_req) begin
`ifdef MISALIGN_TRAP_EN
            pc_d    = load_tgt;
            state_d = (load_tgt[1:0] != 2'b00) ? TRAP : FETCH;
`else
            pc_d    = {load_tgt[31:2], 2'b00};
            state_d = FETCH;
`endif
        end
    end

    // Output logic: handshake levels decoded from the registered state
    always_comb begin
        PC          = pc_q;
        IMem_Addr   = pc_q;
        PC_Plus4    = pc_q + 32'd4;
        IMem_Req    = (state_q == FETCH);
        Instr       = instr_q;
        Instr_PC    = instr_pc_q;
        Instr_Valid = (state_q == HOLD);
`ifdef MISALIGN_TRAP_EN
        Misalign_Trap = (state_q == TRAP);
`else
        Misalign_Trap = 1'b0;
`endif
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: memory responder with programmable wait,
// scoreboard queue of expected {Instr_PC, Instr} pushed at memory Ack.
module tb_pc_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Next_PC;
    logic        Redirect;
    logic [31:0] PC;
    logic [31:0] PC_Plus4;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ack;
    logic [31:0] IMem_Data;
    logic [31:0] Instr;
    logic [31:0] Instr_PC;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic        Misalign_Trap;

    int checks = 0;
    int errors = 0;
    int mem_wait = 0;
    int wcnt = 0;
    logic [63:0] sbq[$];

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clk(Clk), .Reset(Reset), .Next_PC(Next_PC), .Redirect(Redirect),
        .PC(PC), .PC_Plus4(PC_Plus4), .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr),
        .IMem_Ack(IMem_Ack), .IMem_Data(IMem_Data), .Instr(Instr), .Instr_PC(Instr_PC),
        .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready), .Misalign_Trap(Misalign_Trap)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory responder: Ack after mem_wait non-acked request cycles
    task automatic mem_drive();
        if (IMem_Req === 1'b1) begin
            if (wcnt >= mem_wait) begin
                IMem_Ack  = 1'b1;
                IMem_Data = mem_word(IMem_Addr);
                wcnt      = 0;
            end else begin
                IMem_Ack  = 1'b0;
                IMem_Data = 32'hDEAD_BEEF;
                wcnt++;
            end
        end else begin
            IMem_Ack  = 1'b0;
            IMem_Data = 32'hDEAD_BEEF;
            wcnt      = 0;
        end
    endtask

    task automatic step();
        @(negedge Clk);
        mem_drive();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Redirect = 1'b0;
        step();
        step();
        Reset = 1'b0;
        wcnt = 0;
        sbq.delete();
    endtask

    task automatic test_reset();
        int cnt;
        Reset = 1'b1; Redirect = 1'b0; Instr_Ready = 1'b0; Next_PC = 32'h0;
        step();
        step();
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", PC, 32'h0); end
        checks++; if (IMem_Req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", IMem_Req); end
        checks++; if (Instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", Instr); end
        checks++; if (Instr_PC !== 32'h0) begin errors++; $display("FAIL reset_instr_pc got %h want 0", Instr_PC); end
        checks++; if (Instr_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", Instr_Valid); end
        checks++; if (Misalign_Trap !== 1'b0) begin errors++; $display("FAIL reset_trap got %b want 0", Misalign_Trap); end
        mem_wait = 10;
        Reset = 1'b0;
        wcnt = 0;
        cnt = 0;
        while (IMem_Req !== 1'b1 && cnt < 4) begin step(); cnt++; end
        checks++;
        if (IMem_Req !== 1'b1 || cnt < 1 || cnt > 2) begin
            errors++; $display("FAIL first_req got req=%b after %0d cycles want req=1 within 1..2", IMem_Req, cnt);
        end
        checks++; if (IMem_Addr !== 32'h0) begin errors++; $display("FAIL first_addr got %h want 0", IMem_Addr); end
    endtask

    task automatic test_stream();
        logic [31:0] model_pc;
        logic [63:0] e;
        int nreq, nval;
        mem_wait = 0; Instr_Ready = 1'b1;
        do_reset();
        model_pc = 32'h0; Next_PC = 32'h4; nreq = 0; nval = 0;
        step();
        for (int c = 0; c < 12; c++) begin
            Next_PC = model_pc + 32'd4;
            checks++; if (Instr_Valid === IMem_Req) begin errors++; $display("FAIL stream_alt cyc %0d got valid=%b req=%b want opposite", c, Instr_Valid, IMem_Req); end
            checks++; if (PC_Plus4 !== model_pc + 32'd4) begin errors++; $display("FAIL stream_plus4 got %h want %h", PC_Plus4, model_pc + 32'd4); end
            if (IMem_Req === 1'b1) begin
                nreq++;
                checks++; if (IMem_Addr !== model_pc) begin errors++; $display("FAIL stream_addr got %h want %h", IMem_Addr, model_pc); end
                sbq.push_back({model_pc, mem_word(model_pc)});
            end
            if (Instr_Valid === 1'b1) begin
                nval++;
                checks++;
                if (sbq.size() == 0) begin
                    errors++; $display("FAIL stream_sb got empty queue want entry");
                end else begin
                    e = sbq.pop_front();
                    if (Instr !== e[31:0] || Instr_PC !== e[63:32]) begin
                        errors++; $display("FAIL stream_instr got %h@%h want %h@%h", Instr, Instr_PC, e[31:0], e[63:32]);
                    end
                end
                model_pc = model_pc + 32'd4;
            end
            step();
        end
        checks++; if (nreq != 6 || nval != 6) begin errors++; $display("FAIL stream_rate got req=%0d valid=%0d want 6/6", nreq, nval); end
    endtask

    task automatic test_wait();
        logic [63:0] e;
        int nreq;
        bit got;
        mem_wait = 3; Instr_Ready = 1'b1;
        do_reset();
        Next_PC = 32'h4; nreq = 0; got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            if (IMem_Req === 1'b1) begin
                nreq++;
                checks++; if (IMem_Addr !== 32'h0) begin errors++; $display("FAIL wait_addr got %h want 0", IMem_Addr); end
                if (IMem_Ack === 1'b1) sbq.push_back({32'h0, mem_word(32'h0)});
            end
            if (Instr_Valid === 1'b1) begin
                got = 1;
                checks++;
                if (sbq.size() == 0) begin
                    errors++; $display("FAIL wait_sb got empty queue want entry");
                end else begin
                    e = sbq.pop_front();
                    if (Instr !== e[31:0] || Instr_PC !== e[63:32]) begin
                        errors++; $display("FAIL wait_instr got %h@%h want %h@%h", Instr, Instr_PC, e[31:0], e[63:32]);
                    end
                end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL wait_timeout got no valid want valid"); end
        checks++; if (nreq != 4) begin errors++; $display("FAIL wait_req_len got %0d want 4", nreq); end
    endtask

    task automatic test_hold_stall();
        logic [63:0] e;
        int c;
        mem_wait = 0; Instr_Ready = 1'b0; Next_PC = 32'h40;
        do_reset();
        c = 0;
        step();
        while (Instr_Valid !== 1'b1 && c < 5) begin
            if (IMem_Req === 1'b1 && IMem_Ack === 1'b1) sbq.push_back({32'h0, mem_word(32'h0)});
            step(); c++;
        end
        checks++;
        if (sbq.size() == 0 || Instr_Valid !== 1'b1) begin
            errors++; $display("FAIL stall_first got valid=%b want 1", Instr_Valid);
        end else begin
            e = sbq.pop_front();
            if (Instr !== e[31:0] || Instr_PC !== e[63:32]) begin
                errors++; $display("FAIL stall_instr got %h@%h want %h@%h", Instr, Instr_PC, e[31:0], e[63:32]);
            end
        end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (Instr_Valid !== 1'b1 || IMem_Req !== 1'b0 || Instr !== mem_word(32'h0) || Instr_PC !== 32'h0) begin
                errors++; $display("FAIL stall_hold cyc %0d got v=%b r=%b %h@%h want v=1 r=0 %h@0",
                                   k, Instr_Valid, IMem_Req, Instr, Instr_PC, mem_word(32'h0));
            end
        end
        Instr_Ready = 1'b1;
        step();
        checks++;
        if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h40 || Instr_Valid !== 1'b0) begin
            errors++; $display("FAIL stall_release got r=%b addr=%h v=%b want r=1 addr=00000040 v=0", IMem_Req, IMem_Addr, Instr_Valid);
        end
    endtask

    task automatic test_redirect_kill();
        logic [63:0] e;
        bit got, bad_valid;
        mem_wait = 3; Instr_Ready = 1'b1; Next_PC = 32'h4;
        do_reset();
        bad_valid = 0;
        step(); step(); step();
        Redirect = 1'b1; Next_PC = 32'h100;
        step();
        Redirect = 1'b0; Next_PC = 32'h104;
        checks++;
        if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h0 || IMem_Ack !== 1'b1) begin
            errors++; $display("FAIL kill_hold got r=%b addr=%h ack=%b want r=1 addr=0 ack=1", IMem_Req, IMem_Addr, IMem_Ack);
        end
        step();
        checks++;
        if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h100) begin
            errors++; $display("FAIL kill_target got r=%b addr=%h want r=1 addr=00000100", IMem_Req, IMem_Addr);
        end
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            if (Instr_Valid === 1'b1) begin
                got = 1;
                checks++;
                if (sbq.size() == 0) begin
                    errors++; $display("FAIL kill_sb got empty queue want entry");
                end else begin
                    e = sbq.pop_front();
                    if (Instr !== e[31:0] || Instr_PC !== e[63:32]) begin
                        errors++; $display("FAIL kill_instr got %h@%h want %h@%h", Instr, Instr_PC, e[31:0], e[63:32]);
                    end
                end
            end else if (IMem_Req === 1'b1 && IMem_Ack === 1'b1) begin
                sbq.push_back({32'h100, mem_word(32'h100)});
            end
            if (!got) step();
        end
        checks++; if (!got) begin errors++; $display("FAIL kill_timeout got no valid want valid"); end
    endtask

    task automatic test_redirect_misc();
        // Redirect with same-cycle Ack in FETCH
        mem_wait = 0; Instr_Ready = 1'b0; Next_PC = 32'h4;
        do_reset();
        step();
        Redirect = 1'b1; Next_PC = 32'h300;
        step();
        Redirect = 1'b0;
        checks++;
        if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h300 || Instr_Valid !== 1'b0) begin
            errors++; $display("FAIL redir_ack got r=%b addr=%h v=%b want r=1 addr=00000300 v=0", IMem_Req, IMem_Addr, Instr_Valid);
        end
        step();
        checks++; if (Instr_Valid !== 1'b1 || Instr_PC !== 32'h300) begin errors++; $display("FAIL redir_ack_data got v=%b pc=%h want v=1 pc=00000300", Instr_Valid, Instr_PC); end
        // Redirect + Ready together in HOLD
        Redirect = 1'b1; Instr_Ready = 1'b1; Next_PC = 32'h80;
        step();
        Redirect = 1'b0; Instr_Ready = 1'b0;
        checks++;
        if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h80 || Instr_Valid !== 1'b0) begin
            errors++; $display("FAIL redir_hold got r=%b addr=%h v=%b want r=1 addr=00000080 v=0", IMem_Req, IMem_Addr, Instr_Valid);
        end
    endtask

    task automatic test_wrap_reset();
        mem_wait = 5; Instr_Ready = 1'b1;
        do_reset();
        Redirect = 1'b1; Next_PC = 32'hFFFF_FFFC;
        step();
        Redirect = 1'b0;
        checks++; if (PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h want fffffffc", PC); end
        checks++; if (PC_Plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h want 00000000", PC_Plus4); end
        checks++; if (IMem_Req !== 1'b1) begin errors++; $display("FAIL wrap_req got %b want 1", IMem_Req); end
        Redirect = 1'b1; Next_PC = 32'h500;
        step();
        Redirect = 1'b0;
        Reset = 1'b1;
        step();
        checks++;
        if (IMem_Req !== 1'b0 || PC !== 32'h0 || Instr_Valid !== 1'b0) begin
            errors++; $display("FAIL midreset got r=%b pc=%h v=%b want r=0 pc=0 v=0", IMem_Req, PC, Instr_Valid);
        end
        Reset = 1'b0;
        mem_wait = 0;
        step(); step();
        checks++;
        if (Instr_Valid !== 1'b1 || Instr_PC !== 32'h0) begin
            errors++; $display("FAIL midreset_kill got v=%b pc=%h want v=1 pc=0", Instr_Valid, Instr_PC);
        end
    endtask

    task automatic test_misalign();
        mem_wait = 0; Instr_Ready = 1'b0;
        do_reset();
        Redirect = 1'b1; Next_PC = 32'h102;
        step();
        Redirect = 1'b0;
`ifdef MISALIGN_TRAP_EN
        checks++;
        if (Misalign_Trap !== 1'b1 || IMem_Req !== 1'b0 || PC !== 32'h102 || Instr_Valid !== 1'b0) begin
            errors++; $display("FAIL trap_enter got t=%b r=%b pc=%h v=%b want t=1 r=0 pc=00000102 v=0", Misalign_Trap, IMem_Req, PC, Instr_Valid);
        end
        step(); step();
        checks++; if (Misalign_Trap !== 1'b1 || IMem_Req !== 1'b0) begin errors++; $display("FAIL trap_stay got t=%b r=%b want t=1 r=0", Misalign_Trap, IMem_Req); end
        Redirect = 1'b1; Next_PC = 32'h200;
        step();
        Redirect = 1'b0;
        checks++;
        if (Misalign_Trap !== 1'b0 || IMem_Req !== 1'b1 || IMem_Addr !== 32'h200) begin
            errors++; $display("FAIL trap_exit got t=%b r=%b addr=%h want t=0 r=1 addr=00000200", Misalign_Trap, IMem_Req, IMem_Addr);
        end
`else
        checks++;
        if (Misalign_Trap !== 1'b0 || IMem_Req !== 1'b1 || IMem_Addr !== 32'h100) begin
            errors++; $display("FAIL align_force got t=%b r=%b addr=%h want t=0 r=1 addr=00000100", Misalign_Trap, IMem_Req, IMem_Addr);
        end
`endif
    endtask

    initial begin
        Reset = 1'b1; Redirect = 1'b0; Instr_Ready = 1'b0; Next_PC = 32'h0;
        IMem_Ack = 1'b0; IMem_Data = 32'h0;
        test_reset();
        test_stream();
        test_wait();
        test_hold_stall();
        test_redirect_kill();
        test_redirect_misc();
        test_wrap_reset();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
